// File: rtl/decrypt_single_round.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_single_round
// Purpose  : One pipelined AES inverse-cipher round:
//              S1 : InvShiftRows -> InvSubBytes, captures selected round key
//              S2 : AddRoundKey -> InvMixColumns (bypassed on the last round)
//              S3 : optional output register (DEC_ROUND_OUT_REG_EN)
//            Valid/ready flow control lets the controller stall the pipe.
// Macro    : DEC_ROUND_OUT_REG_EN - adds output stage S3 (latency 2 -> 3)
// Ports    : clk, rst            clock / synchronous active-high reset
//            key_len             1 = prev_key, 0 = key_in (sampled on accept)
//            last_round          1 = skip InvMixColumns (sampled on accept)
//            round_valid_in      upstream block valid
//            round_ready_out     block can be accepted this cycle
//            state_in            cipher state, byte 0 = bits [127:120]
//            prev_key, key_in    candidate round keys
//            state_out           round result (registered)
//            round_valid_out     state_out valid
//            round_ready_in      downstream accepts state_out
// Revision : 1.0 - initial release
// ============================================================================
module decrypt_single_round #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_len,
  input  logic                  last_round,
  input  logic                  round_valid_in,
  output logic                  round_ready_out,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] prev_key,
  input  logic [DATA_WIDTH-1:0] key_in,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic                  round_valid_out,
  input  logic                  round_ready_in
);

  // Inverse S-box, index 0 is the leftmost byte.
  localparam logic [0:255][7:0] c_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return c_INV_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [DATA_WIDTH-1:0] r_s1_key;
  logic                  r_s1_last;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_data;

  logic w_s1_load;
  logic w_s2_load;

`ifdef DEC_ROUND_OUT_REG_EN
  logic                  r_s3_valid;
  logic [DATA_WIDTH-1:0] r_s3_data;
  logic                  w_s3_load;

  assign w_s3_load = !r_s3_valid || round_ready_in;
  assign w_s2_load = !r_s2_valid || w_s3_load;
`else
  assign w_s2_load = !r_s2_valid || round_ready_in;
`endif
  assign w_s1_load       = !r_s1_valid || w_s2_load;
  assign round_ready_out = w_s1_load;

  // --------------------------------------------------------------------------
  // S1 datapath: InvShiftRows then InvSubBytes.
  // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_s1_next;
  logic [DATA_WIDTH-1:0] w_key_sel;

  assign w_key_sel = key_len ? prev_key : key_in;

  for (genvar c = 0; c < 4; c++) begin : g_isr_col
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
      localparam int c_DST = 4 * c + r;
      localparam int c_SRC = 4 * ((c - r + 4) % 4) + r;
      assign w_s1_next[127-8*c_DST -: 8] = inv_sbox(state_in[127-8*c_SRC -: 8]);
    end
  end

  // --------------------------------------------------------------------------
  // S2 datapath: AddRoundKey then InvMixColumns.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_ark;
  logic [DATA_WIDTH-1:0] w_imc;
  logic [DATA_WIDTH-1:0] w_s2_next;

  assign w_ark = r_s1_data ^ r_s1_key;

  for (genvar c = 0; c < 4; c++) begin : g_imc_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*c -: 8];
    assign w_a1 = w_ark[119-32*c -: 8];
    assign w_a2 = w_ark[111-32*c -: 8];
    assign w_a3 = w_ark[103-32*c -: 8];
    assign w_imc[127-32*c -: 8] = mul0e(w_a0) ^ mul0b(w_a1) ^ mul0d(w_a2) ^ mul09(w_a3);
    assign w_imc[119-32*c -: 8] = mul09(w_a0) ^ mul0e(w_a1) ^ mul0b(w_a2) ^ mul0d(w_a3);
    assign w_imc[111-32*c -: 8] = mul0d(w_a0) ^ mul09(w_a1) ^ mul0e(w_a2) ^ mul0b(w_a3);
    assign w_imc[103-32*c -: 8] = mul0b(w_a0) ^ mul0d(w_a1) ^ mul09(w_a2) ^ mul0e(w_a3);
  end

  assign w_s2_next = r_s1_last ? w_ark : w_imc;

  // --------------------------------------------------------------------------
  // Pipeline registers. Data only moves with a valid block so a stalled or
  // idle stage keeps its contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= round_valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_load && round_valid_in) begin
      r_s1_data <= w_s1_next;
      r_s1_key  <= w_key_sel;
      r_s1_last <= last_round;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_next;
      end
    end
  end

`ifdef DEC_ROUND_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_data  <= '0;
    end else if (w_s3_load) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_data <= r_s2_data;
      end
    end
  end

  assign state_out       = r_s3_data;
  assign round_valid_out = r_s3_valid;
`else
  assign state_out       = r_s2_data;
  assign round_valid_out = r_s2_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decrypt_single_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt_single_round
// Purpose  : Self-checking bench for decrypt_single_round. A behavioural
//            inverse-round model (S-box derived from GF(2^8) inversion and
//            the affine map) feeds an in-order scoreboard with accept times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decrypt_single_round;

`ifdef DEC_ROUND_OUT_REG_EN
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 2;
`endif

  logic         clk;
  logic         rst;
  logic         key_len;
  logic         last_round;
  logic         round_valid_in;
  logic         round_ready_out;
  logic [127:0] state_in;
  logic [127:0] prev_key;
  logic [127:0] key_in;
  logic [127:0] state_out;
  logic         round_valid_out;
  logic         round_ready_in;

  decrypt_single_round #(.DATA_WIDTH(128)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .key_len         (key_len),
    .last_round      (last_round),
    .round_valid_in  (round_valid_in),
    .round_ready_out (round_ready_out),
    .state_in        (state_in),
    .prev_key        (prev_key),
    .key_in          (key_in),
    .state_out       (state_out),
    .round_valid_out (round_valid_out),
    .round_ready_in  (round_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    logic [127:0] d;
    int           acc;
  } ent_t;
  ent_t q[$];

  logic [7:0] isb [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p ^= a;
      a = a << 1;
      if ((a & 'h100) != 0) a ^= 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic int rotl8(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 'hff;
  endfunction

  function automatic int imc_coef(input int k);
    case (k)
      0:       return 'h0e;
      1:       return 'h0b;
      2:       return 'h0d;
      default: return 'h09;
    endcase
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s;
      if (x != 0) begin
        inv = 1;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      isb[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int k = 0; k < 16; k++) b[k] = st[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = isb[b[4*((c-r+4)%4)+r]] ^ key[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int acc = 0;
        if (last) acc = int'(t[4*c+r]);
        else
          for (int j = 0; j < 4; j++) acc ^= gmul(imc_coef((j - r + 4) % 4), int'(t[4*c+j]));
        res[127-8*(4*c+r) -: 8] = acc[7:0];
      end
    return res;
  endfunction

  // One clock cycle: drive inputs, check outputs against the scoreboard,
  // then account for the handshakes that the coming edge will perform.
  task automatic step(input logic v, input logic rdy, input logic [127:0] st,
                      input logic [127:0] pk, input logic [127:0] ki,
                      input logic kl, input logic lr, input logic r,
                      input logic use_exp, input logic [127:0] exp_v);
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    rst = r; round_valid_in = v; round_ready_in = rdy; state_in = st;
    prev_key = pk; key_in = ki; key_len = kl; last_round = lr;
    #1;
    exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= c_LAT);
    exp_ready = (q.size() < c_LAT) || rdy;
    check("valid_out", {127'd0, round_valid_out}, {127'd0, exp_valid});
    check("ready_out", {127'd0, round_ready_out}, {127'd0, exp_ready});
    if (exp_valid) check("state_out", state_out, q[0].d);
    if (r) begin
      q.delete();
    end else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (v && exp_ready) begin
        ent_t e;
        e.d   = use_exp ? exp_v : ref_round(st, kl ? pk : ki, lr);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_rand(input logic rdy);
    step(1'b1, rdy, rnd128(), rnd128(), rnd128(), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; round_valid_in = 1'b0; round_ready_in = 1'b1; state_in = '0;
    prev_key = '0; key_in = '0; key_len = 1'b0; last_round = 1'b0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state_out", state_out, '0);
    check("reset_valid_out", {127'd0, round_valid_out}, 128'd0);
    check("reset_ready_out", {127'd0, round_ready_out}, 128'd1);

    // Known vectors, constant expectations
    step(1'b1, 1'b1, 128'h6353e08c0960e104cd70b751bacad0e7, '0,
         128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1, 1'b0,
         1'b1, 128'h00112233445566778899aabbccddeeff);
    idle(c_LAT + 1);
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, {16{8'h52}});
    step(1'b1, 1'b1, '0, {16{8'h52}}, {16{8'hff}}, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    idle(c_LAT + 1);

    // Back-to-back then stall while still offering blocks
    for (int i = 0; i < 4; i++) send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle(c_LAT + 4);

    // Reset with the pipe full
    for (int i = 0; i < c_LAT; i++) send_rand(1'b0);
    step(1'b1, 1'b0, rnd128(), '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(1);
    check("midrst_state_out", state_out, '0);
    idle(c_LAT + 2);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) send_rand(1'($urandom_range(0, 3) != 0));
      else step(1'b0, 1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(),
                1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    idle(c_LAT + 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
